// File: rtl/mux2_arb_pkg.sv
// Shared types and defaults for the two-requester writeback arbiter.
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  localparam int MAX_BURST_DEF = 8;

endpackage

// File: rtl/mux2_arbiter_mux.sv
// Plain 2:1 datapath mux shared by the two requesters.
module mux2_arbiter_mux #(
  parameter int WIDTH = 32
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter with packet locking in front of a shared registered output stage.
module mux2_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             in1_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic             out_last,
  input  logic             out_ready,
  output logic             err_overrun
);

  localparam int CW = $clog2(MAX_BURST + 1);

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_src_q, out_src_d;
  logic             out_last_q, out_last_d;
  logic             err_q, err_d;

  logic             room;
  logic             accept;
  logic [WIDTH:0]   mux_out;
  logic             beat_last;
  logic [CW-1:0]    cnt_inc;

  // With nobody requesting in IDLE the select parks on its previous value.
  always_comb begin
    sel_d = sel_q;
    unique case (state_q)
      IDLE: begin
        if (in0_valid && in1_valid) sel_d = rr_q;
        else if (in0_valid)         sel_d = 1'b0;
        else if (in1_valid)         sel_d = 1'b1;
      end
      LOCK0:   sel_d = 1'b0;
      LOCK1:   sel_d = 1'b1;
      default: sel_d = sel_q;
    endcase
  end

  assign sel       = sel_d;
  assign room      = !out_valid_q || out_ready;
  assign in0_ready = !sel_d && room && (state_q == IDLE || state_q == LOCK0);
  assign in1_ready =  sel_d && room && (state_q == IDLE || state_q == LOCK1);
  assign accept    = (in0_valid && in0_ready) || (in1_valid && in1_ready);

  mux2_arbiter_mux #(.WIDTH(WIDTH + 1)) u_mux (
    .sel (sel_d),
    .in0 ({in0_last, in0_data}),
    .in1 ({in1_last, in1_data}),
    .out (mux_out)
  );

  assign beat_last = mux_out[WIDTH];
  assign cnt_inc   = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    err_d       = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_last_d  = out_last_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_out[WIDTH-1:0];
      out_src_d   = sel_d;
      out_last_d  = beat_last;

      if (state_q == IDLE) begin
        if (beat_last) begin
          rr_d = ~sel_d;
        end else begin
          state_d = sel_d ? LOCK1 : LOCK0;
          cnt_d   = CW'(1);
        end
      end else if (beat_last) begin
        state_d = IDLE;
        rr_d    = ~sel_d;
        cnt_d   = '0;
      end else if (cnt_inc == CW'(MAX_BURST)) begin
        // Burst ran too long: drop the lock so the other side gets a turn.
        state_d = IDLE;
        rr_d    = ~sel_d;
        cnt_d   = '0;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_inc;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      cnt_q       <= '0;
      sel_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_src     = out_src_q;
  assign out_last    = out_last_q;
  assign err_overrun = err_q;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Randomized and directed checks of mux2_arbiter against a transaction-level reference model.
module tb_mux2_arbiter;

  localparam int WIDTH     = 32;
  localparam int MAX_BURST = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in0_valid, in0_last, in0_ready;
  logic [WIDTH-1:0] in0_data;
  logic             in1_valid, in1_last, in1_ready;
  logic [WIDTH-1:0] in1_data;
  logic             sel, out_valid, out_src, out_last, out_ready, err_overrun;
  logic [WIDTH-1:0] out_data;

  mux2_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
    .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_last(out_last), .out_ready(out_ready), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: who owns the bus, beats taken so far, whose turn is next.
  int          m_owner;       // -1 = nobody holds a packet
  int          m_beats;
  int          m_turn;
  int          m_last_pick;
  bit          m_ov, m_src, m_last, m_err;
  logic [31:0] m_data;
  int          err_seen;

  function automatic void model_reset();
    m_owner = -1; m_beats = 0; m_turn = 0; m_last_pick = 0;
    m_ov = 0; m_src = 0; m_last = 0; m_err = 0; m_data = '0;
  endfunction

  // One clock of traffic: drive, check the combinational grant, clock, check the register stage.
  task automatic cyc(input bit v0, input logic [31:0] d0, input bit l0,
                     input bit v1, input logic [31:0] d1, input bit l1, input bit ordy);
    int  pick;
    bit  room, take, tl;
    logic [31:0] td;
    @(negedge clk);
    in0_valid = v0; in0_data = d0; in0_last = l0;
    in1_valid = v1; in1_data = d1; in1_last = l1;
    out_ready = ordy;
    #1;
    if (m_owner >= 0)   pick = m_owner;
    else if (v0 && v1)  pick = m_turn;
    else if (v0)        pick = 0;
    else if (v1)        pick = 1;
    else                pick = m_last_pick;
    room = !m_ov || ordy;
    take = room && (pick == 0 ? v0 : v1);
    td   = (pick == 0) ? d0 : d1;
    tl   = (pick == 0) ? l0 : l1;
    chk("sel", 64'(sel), 64'(pick));
    chk("in0_ready", 64'(in0_ready), 64'(room && pick == 0));
    chk("in1_ready", 64'(in1_ready), 64'(room && pick == 1));

    @(posedge clk);
    #1;
    m_last_pick = pick;
    m_err = 0;
    if (take) begin
      m_ov = 1; m_data = td; m_src = pick[0]; m_last = tl;
      if (tl) begin
        m_owner = -1; m_beats = 0; m_turn = 1 - pick;
      end else if (m_owner < 0) begin
        m_owner = pick; m_beats = 1;
      end else begin
        m_beats++;
        if (m_beats == MAX_BURST) begin
          m_owner = -1; m_beats = 0; m_turn = 1 - pick; m_err = 1;
        end
      end
    end else if (ordy) begin
      m_ov = 0;
    end
    if (err_overrun) err_seen++;
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("err_overrun", 64'(err_overrun), 64'(m_err));
    if (m_ov) begin
      chk("out_data", 64'(out_data), 64'(m_data));
      chk("out_src", 64'(out_src), 64'(m_src));
      chk("out_last", 64'(out_last), 64'(m_last));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, 0, 0, '0, 0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    in0_valid = 0; in0_data = '0; in0_last = 0;
    in1_valid = 0; in1_data = '0; in1_last = 0;
    out_ready = 1'b1;
    model_reset();
    err_seen = 0;
    #23;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_src", 64'(out_src), 64'd0);
    chk("rst_sel", 64'(sel), 64'd0);
    chk("rst_err", 64'(err_overrun), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Alternating single beats from both sides.
    for (int i = 0; i < 6; i++) cyc(1, 32'hA000_0000 + i, 1, 1, 32'hB000_0000 + i, 1, 1);
    idle(1);

    // Three-beat packet from in0 while in1 keeps asking.
    cyc(1, 32'hA0, 0, 1, 32'hB0, 1, 1);
    cyc(1, 32'hA1, 0, 1, 32'hB0, 1, 1);
    cyc(1, 32'hA2, 1, 1, 32'hB0, 1, 1);
    cyc(0, 32'h0,  0, 1, 32'hB0, 1, 1);
    idle(1);

    // Output stall for four cycles, then release.
    cyc(1, 32'hC0, 1, 0, 32'h0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 32'hC1, 1, 1, 32'hD1, 1, 0);
    cyc(1, 32'hC1, 1, 1, 32'hD1, 1, 1);
    cyc(0, 32'h0, 0, 0, 32'h0, 0, 1);
    chk("stall_rel_data", 64'(out_data), 64'h0000_00D1);
    idle(1);

    // Overlong burst from in1 is cut after MAX_BURST beats; in0 then wins.
    err_seen = 0;
    for (int i = 0; i < MAX_BURST; i++) cyc(0, '0, 0, 1, 32'hE0 + i, 0, 1);
    chk("overrun_pulses", 64'(err_seen), 64'd1);
    cyc(1, 32'hF0, 1, 1, 32'hE9, 0, 1);
    chk("post_overrun_src", 64'(out_src), 64'd0);
    cyc(0, '0, 0, 0, 32'h0, 1, 1);
    idle(1);

    // Asynchronous reset in the middle of an in1 packet with a beat pending.
    cyc(0, '0, 0, 1, 32'h1234, 0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    in0_valid = 0; in1_valid = 0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_sel", 64'(sel), 64'd0);
    chk("arst_err", 64'(err_overrun), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 32'h5A, 1, 1, 32'h5B, 1, 1);
    chk("post_rst_src", 64'(out_src), 64'd0);
    idle(1);

    // Lone in1 single beats: granted every cycle.
    for (int i = 0; i < 5; i++) cyc(0, '0, 0, 1, 32'h700 + i, 1, 1);
    idle(1);

    // Random traffic, including mid-packet valid drops and backpressure.
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
          $urandom_range(0, 4) != 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
